// File: rtl/lcd_sequencer_pkg.sv
// rtl/lcd_sequencer_pkg.sv - shared types and constants for the LCD sequencer
package lcd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int BUF_DEPTH     = 32;
    localparam int REFRESH_STEPS = 34;

    localparam logic [7:0] CMD_FUNC_SET       = 8'h38;
    localparam logic [7:0] CMD_DISP_ON        = 8'h0C;
    localparam logic [7:0] CMD_CLEAR          = 8'h01;
    localparam logic [7:0] CMD_ENTRY_MODE     = 8'h06;
    localparam logic [7:0] CMD_LINE1_ADDR     = 8'h80;
    localparam logic [7:0] LINE2_ADDR_DEFAULT = 8'hC0;

    // Power-up command list; entries past the fourth repeat entry mode, which is harmless
    function automatic logic [7:0] init_cmd(input logic [5:0] idx);
        case (idx)
            6'd0:    init_cmd = CMD_FUNC_SET;
            6'd1:    init_cmd = CMD_DISP_ON;
            6'd2:    init_cmd = CMD_CLEAR;
            default: init_cmd = CMD_ENTRY_MODE;
        endcase
    endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// rtl/lcd_char_buf.sv - 32x8 character buffer, one sync write port, one async read port
module lcd_char_buf
    import lcd_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [BUF_DEPTH];

    // Reset fills the display with spaces; host writes land on the clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= 8'h20;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - runs the LCD init list, then refreshes both lines whenever the buffer changes
module lcd_sequencer
    import lcd_sequencer_pkg::*;
#(
    parameter int         NUM_INIT   = 4,
    parameter logic [7:0] LINE2_ADDR = LINE2_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       is_ready,
    input  logic       cmd_done,
    output logic       rs_out,
    output logic       rw_out,
    output logic [7:0] data_out,
    output logic       execute,
    output logic       init_done,
    output logic       busy
);

    localparam logic [5:0] INIT_LAST    = 6'(NUM_INIT - 1);
    localparam logic [5:0] REFRESH_LAST = 6'(REFRESH_STEPS - 1);

    state_t     state;
    state_t     next_state;
    logic [5:0] step;
    logic [5:0] last_step;
    logic       dirty;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       load_rs;
    logic [7:0] load_data;
    logic       step_done;

    lcd_char_buf u_char_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign last_step = init_done ? REFRESH_LAST : INIT_LAST;
    assign rw_out    = 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; RELEASE waits for the controller to go idle before moving on
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (!init_done || (dirty && is_ready)) next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_ISSUE;
            ST_ISSUE:   if (cmd_done) next_state = ST_RELEASE;
            ST_RELEASE: if (is_ready) next_state = (step == last_step) ? ST_IDLE : ST_LOAD;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Step content selection: refresh steps 1-16 read cells 0-15, steps 18-33 read cells 16-31
    always_comb begin
        busy      = (state != ST_IDLE) || !init_done;
        step_done = (state == ST_RELEASE) && is_ready;
        rd_addr   = (step <= 6'd16) ? 5'(step - 6'd1) : 5'(step - 6'd2);
        load_rs   = 1'b0;
        load_data = 8'h00;
        if (!init_done) begin
            load_data = init_cmd(step);
        end else if (step == 6'd0) begin
            load_data = CMD_LINE1_ADDR;
        end else if (step == 6'd17) begin
            load_data = LINE2_ADDR;
        end else begin
            load_rs   = 1'b1;
            load_data = rd_data;
        end
    end

    // Datapath: step counter, dirty/init flags, held bus outputs and registered execute
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step      <= 6'd0;
            dirty     <= 1'b0;
            init_done <= 1'b0;
            execute   <= 1'b0;
            rs_out    <= 1'b0;
            data_out  <= 8'h00;
        end else begin
            execute <= (next_state == ST_ISSUE);
            if (state == ST_LOAD) begin
                rs_out   <= load_rs;
                data_out <= load_data;
            end
            if (step_done) begin
                step <= (step == last_step) ? 6'd0 : step + 6'd1;
                if (step == last_step && !init_done) begin
                    init_done <= 1'b1;
                end
            end
            // A host write always wins so a change mid-refresh is never lost
            if (wr_en || (step_done && step == last_step && !init_done)) begin
                dirty <= 1'b1;
            end else if (state == ST_LOAD && init_done && step == 6'd0) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have the following ports, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  host character write strobe, one cycle per write.
- wr_addr  in  5  character cell (0-15 line 1, 16-31 line 2).
- wr_data  in  8  character code.
- is_ready  in  1  LCD controller idle and accepting.
- cmd_done  in  1  LCD controller finished current transaction; holds high until execute falls.
- rs_out  out  1  register select to controller (0 = instruction, 1 = data).
- rw_out  out  1  read/write to controller; always 0 (write).
- data_out  out  8  byte to controller.
- execute  out  1  transaction request to controller.
- init_done  out  1  power-up command list complete.
- busy  out  1  init or refresh in progress.
REQ-002 SHALL have the following parameters (name, default, meaning):
- NUM_INIT, 4, number of init commands.
- LINE2_ADDR, 8'hC0, DDRAM set-address command for line 2.

Function
REQ-003 SHALL hold a 32x8 character buffer; wr_en writes wr_data at wr_addr on the same clock edge; writes are accepted in every state.
REQ-004 SHALL run the init list 8'h38, 8'h0C, 8'h01, 8'h06 (rs_out = 0) once after reset, then set init_done = 1 and dirty = 1.
REQ-005 SHALL perform a refresh as 34 steps:
- step 0: 8'h80 (rs_out = 0).
- steps 1-16: buffer[0..15] (rs_out = 1).
- step 17: LINE2_ADDR (rs_out = 0).
- steps 18-33: buffer[16..31] (rs_out = 1).
REQ-006 SHALL implement states IDLE, LOAD, ISSUE, RELEASE:
- IDLE -> LOAD when !init_done, or when dirty && is_ready.
- LOAD: latch rs_out/data_out for the current step; clear dirty when the step is refresh step 0; -> ISSUE next cycle.
- ISSUE: execute = 1; -> RELEASE on cmd_done.
- RELEASE: execute = 0; on is_ready, advance step and -> LOAD if steps remain, else -> IDLE.
REQ-007 SHALL keep rs_out, data_out and rw_out stable from LOAD exit until RELEASE exit.
REQ-008 SHALL assert execute registered, the first cycle after LOAD, and deassert it the cycle after cmd_done is sampled high.
REQ-009 SHALL set dirty on any wr_en; a write during a refresh (after step 0) SHALL leave dirty = 1, so that exactly one further full refresh follows.
REQ-010 SHALL give wr_en priority over the dirty clear when both occur in the same cycle (dirty stays 1).
REQ-011 SHALL drive busy = 1 whenever state != IDLE, or when !init_done.
REQ-012 SHALL wrap the step counter to 0 at the end of each list; it SHALL never index beyond step 33.

Reset
REQ-013 rst = 0 SHALL asynchronously force state = IDLE, step = 0, dirty = 0, init_done = 0, execute = 0, rs_out = 0, rw_out = 0, data_out = 8'h00, and buffer contents = 8'h20 (space).
REQ-014 Reset during an in-flight transaction SHALL drop execute immediately and restart the init list on release.

Structure
REQ-015 The shared package SHALL hold: the state encoding, the init command constants, 8'h80, LINE2_ADDR default, the refresh step count (34) and the buffer depth (32).
REQ-016 The character buffer SHALL be a sub-module lcd_char_buf (32x8, one synchronous write port, one asynchronous read port).

Verification
REQ-017 The bench SHALL use a controller model that asserts cmd_done 5 cycles after execute rises and raises is_ready 1 cycle after execute falls, and SHALL cover:
- Reset release, no writes: data_out sequence 38, 0C, 01, 06, then 80, sixteen 20s, C0, sixteen 20s (rs_out pattern per REQ-005); init_done rises after the 4th command; busy = 0 afterwards.
- Idle write wr_addr = 5, wr_data = 8'h41: exactly one refresh; step 6 carries 8'h41 with rs_out = 1.
- Write addr 20 = 8'h5A during refresh step 10: current refresh completes, a second refresh follows, and 8'h5A appears at step 22.
- wr_en and the step-0 dirty clear in the same cycle: dirty remains 1 and a second refresh occurs.
- rst pulsed low while execute = 1 at refresh step 12: execute = 0 in the same cycle; the init list reissues starting with 8'h38.
- cmd_done withheld for 1000 cycles: execute stays 1, and outputs stay stable throughout.
